// File: rtl/alu_seq.sv
// Sequential ALU: 1-cycle ADD/SUB/AND/XOR/OR, multi-cycle SHL/SHR (1 bit/cycle) and shift-add MUL.
// Define ALU_SAT_EN to saturate ADD/SUB on signed overflow; otherwise they wrap.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovr,
  output logic             zero,
  output logic             neg
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d, hi_q, hi_d, lo_q, lo_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, ovr_q, ovr_d, zero_q, zero_d, neg_q, neg_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             fin, ncout, novr, nout;
  logic [WIDTH-1:0] nres, step_lo, step_hi;
  logic [WIDTH:0]   sum, madd;
  logic [SW-1:0]    shamt;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovr_d    = ovr_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fin      = 1'b0;
    nres     = '0;
    ncout    = 1'b0;
    novr     = 1'b0;
    nout     = 1'b0;
    step_lo  = lo_q;
    step_hi  = hi_q;
    shamt    = b[SW-1:0];
    // op[0] selects subtract: a + ~b + 1
    sum  = {1'b0, a} + {1'b0, b ^ {WIDTH{op[0]}}} + {{WIDTH{1'b0}}, op[0]};
    madd = {1'b0, hi_q} + ({1'b0, opa_q} & {(WIDTH+1){lo_q[0]}});

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          case (op)
            OP_ADD, OP_SUB: begin
              nres  = sum[M:0];
              ncout = sum[WIDTH];
              novr  = (op[0] ? (a[M] != b[M]) : (a[M] == b[M])) && (sum[M] != a[M]);
`ifdef ALU_SAT_EN
              if (novr) nres = a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
`endif
              fin = 1'b1;
            end
            OP_AND: begin nres = a & b; fin = 1'b1; end
            OP_XOR: begin nres = a ^ b; fin = 1'b1; end
            OP_OR:  begin nres = a | b; fin = 1'b1; end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                nres = a;
                fin  = 1'b1;
              end else begin
                lo_d    = a;
                cnt_d   = shamt - SW'(1);
                state_d = EXEC;
                busy_d  = 1'b1;
              end
            end
            default: begin
              opa_d   = a;
              hi_d    = '0;
              lo_d    = b;
              cnt_d   = SW'(WIDTH - 1);
              state_d = EXEC;
              busy_d  = 1'b1;
            end
          endcase
        end
      end
      default: begin
        case (op_q)
          OP_SHL: begin step_lo = lo_q << 1; nout = lo_q[M]; end
          OP_SHR: begin step_lo = lo_q >> 1; nout = lo_q[0]; end
          default: begin
            step_hi = madd[WIDTH:1];
            step_lo = {madd[0], lo_q[M:1]};
          end
        endcase
        if (cnt_q == '0) begin
          fin     = 1'b1;
          nres    = step_lo;
          ncout   = nout;
          novr    = (op_q == OP_MUL) && (step_hi != '0);
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - SW'(1);
          lo_d  = step_lo;
          hi_d  = step_hi;
        end
      end
    endcase

    if (fin) begin
      result_d = nres;
      cout_d   = ncout;
      ovr_d    = novr;
      zero_d   = (nres == '0);
      neg_d    = nres[M];
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovr_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovr_q    <= ovr_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovr    = ovr_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
endmodule
